// File: rtl/systolic_pkg.sv
// Shared types and default sizes for the systolic result drain.
package systolic_pkg;

    localparam int unsigned DEF_DIM    = 4;
    localparam int unsigned DEF_ELEM_W = 32;
    localparam int unsigned NUM_ELEM   = DEF_DIM * DEF_DIM;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StFlush
    } drain_state_t;

endpackage

// File: rtl/result_shreg.sv
// Parallel-load buffer that shifts one element per step toward the head.
// Element 0 sits in the most significant slot, so the head always presents the next element.
module result_shreg #(
    parameter int unsigned ELEM_W   = 32,
    parameter int unsigned NUM_ELEM = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load,
    input  logic                         shift_en,
    input  logic [NUM_ELEM*ELEM_W-1:0]   d,
    output logic [ELEM_W-1:0]            head
);

    localparam int unsigned NW = NUM_ELEM * ELEM_W;

    logic [NW-1:0] buf_q;

    // Load wins over shift; zeros fill in behind the shifted-out element.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q <= '0;
        end else if (load) begin
            buf_q <= d;
        end else if (shift_en) begin
            buf_q <= {buf_q[NW-ELEM_W-1:0], {ELEM_W{1'b0}}};
        end
    end

    assign head = buf_q[NW-1 -: ELEM_W];

endmodule

// File: rtl/systolic_result_drain.sv
// Captures the systolic multiplier result on the rising edge of done and streams the
// elements row-major over valid/ready, pulsing array_clear once after capture.
// Optional feature macro: DRAIN_PARITY_EN adds m_parity (even parity of m_data).
module systolic_result_drain
    import systolic_pkg::*;
#(
    parameter int unsigned ELEM_W = DEF_ELEM_W,
    parameter int unsigned DIM    = DEF_DIM
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DIM*DIM*ELEM_W-1:0]     y_in,
    input  logic                          done_in,
    output logic                          array_clear,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [ELEM_W-1:0]             m_data,
    output logic [$clog2(DIM*DIM)-1:0]    m_index,
    output logic                          m_last,
    output logic                          busy,
    output logic                          overrun
`ifdef DRAIN_PARITY_EN
    ,
    output logic                          m_parity
`endif
);

    localparam int unsigned NUM_E = DIM * DIM;
    localparam int unsigned IDX_W = $clog2(NUM_E);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_E - 1);
    localparam logic [IDX_W-1:0] PRE_LAST = IDX_W'(NUM_E - 2);

    drain_state_t state;
    logic         done_q;
    logic         done_rise;
    logic         load;
    logic         shift_en;

    assign done_rise = done_in & ~done_q;

    // Buffer control: capture only from idle, advance on every accepted beat.
    always_comb begin
        load     = 1'b0;
        shift_en = 1'b0;
        if (state == StIdle) begin
            load = done_rise;
        end
        if (state == StStream) begin
            shift_en = m_valid & m_ready;
        end
    end

    result_shreg #(
        .ELEM_W   (ELEM_W),
        .NUM_ELEM (NUM_E)
    ) u_shreg (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .shift_en (shift_en),
        .d        (y_in),
        .head     (m_data)
    );

    // Drain FSM with edge detect, index counter and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            done_q      <= 1'b0;
            array_clear <= 1'b0;
            m_valid     <= 1'b0;
            m_index     <= '0;
            m_last      <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            done_q      <= done_in;
            array_clear <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (done_rise) begin
                        state       <= StStream;
                        array_clear <= 1'b1;
                        m_valid     <= 1'b1;
                        busy        <= 1'b1;
                        m_index     <= '0;
                        m_last      <= 1'b0;
                    end
                end
                StStream: begin
                    if (done_rise) begin
                        overrun <= 1'b1;
                    end
                    if (m_valid && m_ready) begin
                        if (m_index == LAST_IDX) begin
                            state   <= StFlush;
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            busy    <= 1'b0;
                        end else begin
                            m_index <= m_index + 1'b1;
                            m_last  <= (m_index == PRE_LAST);
                        end
                    end
                end
                StFlush: begin
                    if (done_rise) begin
                        overrun <= 1'b1;
                    end
                    // Hold here until done drops so a level-high done cannot recapture.
                    if (!done_in) begin
                        state   <= StIdle;
                        m_index <= '0;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

`ifdef DRAIN_PARITY_EN
    assign m_parity = ^m_data;
`endif

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain; parity checks compile in with DRAIN_PARITY_EN.
module tb_systolic_result_drain;

    localparam int unsigned ELEM_W = 32;
    localparam int unsigned DIM    = 4;
    localparam int unsigned NE     = DIM * DIM;
    localparam int unsigned NW     = NE * ELEM_W;

    logic              clk = 1'b0;
    logic              reset;
    logic [NW-1:0]     y_in;
    logic              done_in;
    logic              array_clear;
    logic              m_valid;
    logic              m_ready;
    logic [ELEM_W-1:0] m_data;
    logic [3:0]        m_index;
    logic              m_last;
    logic              busy;
    logic              overrun;
`ifdef DRAIN_PARITY_EN
    logic              m_parity;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    systolic_result_drain #(
        .ELEM_W (ELEM_W),
        .DIM    (DIM)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .y_in        (y_in),
        .done_in     (done_in),
        .array_clear (array_clear),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_index     (m_index),
        .m_last      (m_last),
        .busy        (busy),
        .overrun     (overrun)
`ifdef DRAIN_PARITY_EN
        ,
        .m_parity    (m_parity)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pattern 0: C[i][j] = i*16+j. Pattern 1: tagged ramp. Pattern 2: parity corner values.
    function automatic logic [31:0] elem(input int pat, input int k);
        case (pat)
            0:       elem = 32'((k / 4) * 16 + (k % 4));
            1:       elem = 32'hC0DE_0000 + 32'(k) * 32'h0000_0101;
            default: elem = (k == 0) ? 32'h7 : (k == 1) ? 32'h3 : 32'(k) * 32'h0101_0101;
        endcase
    endfunction

    function automatic logic [NW-1:0] build(input int pat);
        logic [NW-1:0] v;
        v = '0;
        for (int k = 0; k < int'(NE); k++) begin
            v[NW-1-k*ELEM_W -: ELEM_W] = elem(pat, k);
        end
        return v;
    endfunction

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("idle_valid", 64'(m_valid), 64'd0);
            check("idle_clear", 64'(array_clear), 64'd0);
            check("idle_busy", 64'(busy), 64'd0);
        end
    endtask

    // mode 0: ready always high; mode 1: ready toggles starting low.
    // hook 1: second done rise at beat 5; hook 2: reset at beat 7; hook 3: done held high.
    task automatic run_drain(input int pat, input int mode, input int hook);
        int beat = 0;
        int cyc = 0;
        int clears = 0;
        bit fired = 0;
        bit rst_hit = 0;
        bit prev_stall = 0;
        logic [31:0] prev = '0;
        y_in    = build(pat);
        done_in = 1'b1;
        m_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("cap_valid", 64'(m_valid), 64'd1);
        check("cap_busy", 64'(busy), 64'd1);
        check("cap_index", 64'(m_index), 64'd0);
        // Buffer must be independent of y_in after capture.
        y_in = ~y_in;
        while (beat < int'(NE) && cyc < 100 && !rst_hit) begin
            if (array_clear) clears++;
            if (cyc == 2 && hook != 3) done_in = 1'b0;
            if (hook == 1 && fired) done_in = 1'b0;
            check("valid", 64'(m_valid), 64'd1);
            check("index", 64'(m_index), 64'(beat));
            check("data", 64'(m_data), 64'(elem(pat, beat)));
            check("last", 64'(m_last), 64'(beat == 15));
`ifdef DRAIN_PARITY_EN
            check("parity", 64'(m_parity), 64'(^elem(pat, beat)));
            if (pat == 2 && beat == 0) check("parity_7", 64'(m_parity), 64'd1);
            if (pat == 2 && beat == 1) check("parity_3", 64'(m_parity), 64'd0);
`endif
            if (prev_stall) check("stall_hold", 64'(m_data), 64'(prev));
            if (hook == 2 && beat == 7) begin
                reset = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check("rst_valid", 64'(m_valid), 64'd0);
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_index", 64'(m_index), 64'd0);
                check("rst_data", 64'(m_data), 64'd0);
                check("rst_overrun", 64'(overrun), 64'd0);
                check("rst_clear", 64'(array_clear), 64'd0);
                reset   = 1'b0;
                m_ready = 1'b0;
                rst_hit = 1;
            end else begin
                if (hook == 1 && beat == 5 && !fired) begin
                    done_in = 1'b1;
                    fired   = 1;
                end
                m_ready    = (mode == 0) ? 1'b1 : (cyc % 2 == 1);
                prev       = m_data;
                prev_stall = !m_ready;
                @(posedge clk);
                if (m_ready) beat++;
                @(negedge clk);
                cyc++;
            end
        end
        m_ready = 1'b0;
        if (!rst_hit) begin
            check("beats", 64'(beat), 64'd16);
            check("cycles", 64'(cyc), (mode == 0) ? 64'd16 : 64'd32);
            check("end_valid", 64'(m_valid), 64'd0);
            check("end_busy", 64'(busy), 64'd0);
            check("end_last", 64'(m_last), 64'd0);
            check("clears", 64'(clears), 64'd1);
            check("overrun", 64'(overrun), 64'(hook == 1));
        end
    endtask

    initial begin
        reset   = 1'b1;
        done_in = 1'b0;
        m_ready = 1'b0;
        y_in    = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset_valid", 64'(m_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_clear", 64'(array_clear), 64'd0);
        check("reset_index", 64'(m_index), 64'd0);
        check("reset_data", 64'(m_data), 64'd0);
        check("reset_overrun", 64'(overrun), 64'd0);
`ifdef DRAIN_PARITY_EN
        check("reset_parity", 64'(m_parity), 64'd0);
`endif
        reset = 1'b0;
        idle_check(2);

        // Full-rate drain, then no recapture.
        run_drain(0, 0, 0);
        idle_check(3);

        // Alternating backpressure.
        run_drain(1, 1, 0);
        idle_check(2);

        // Second done edge mid-stream sets sticky overrun.
        run_drain(1, 0, 1);
        idle_check(2);
        check("overrun_sticky", 64'(overrun), 64'd1);

        // Reset mid-stream, then a fresh capture restarts at index 0.
        run_drain(0, 0, 2);
        idle_check(2);
        run_drain(0, 0, 0);
        idle_check(2);

        // Done held high after drain parks in flush; drop and re-raise recaptures.
        run_drain(1, 0, 3);
        idle_check(4);
        done_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        run_drain(0, 0, 0);
        idle_check(2);

        // Parity corner elements.
        run_drain(2, 0, 0);
        idle_check(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
